// File: rtl/leaf_stream_buffer_pkg.sv
// Shared types and sizing helpers for the leaf stream buffer.
package leaf_pkg;

  localparam int unsigned LEAF_DATA_W = 8;

  typedef logic [LEAF_DATA_W-1:0] leaf_word_t;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PARTIAL,
    OCC_FULL
  } leaf_occ_e;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int unsigned LEAF_LVL_W(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/leaf_stream_buffer_if.sv
// Ready/valid stream bundle plus buffer status; slave side is the buffer.
interface leaf_stream_buffer_if
  import leaf_pkg::*;
#(
  parameter int unsigned DATA_W = LEAF_DATA_W,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 16
);

  localparam int unsigned LVL_W = LEAF_LVL_W(DEPTH);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic [LVL_W-1:0]  level;
  logic [CNT_W-1:0]  xfer_cnt;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, level, xfer_cnt
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, level, xfer_cnt
  );

endinterface

// File: rtl/leaf_stream_buffer_mem.sv
// DEPTH x DATA_W storage array, synchronous write, asynchronous read, no reset.
module leaf_buf_mem #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/leaf_stream_buffer.sv
// Elastic ready/valid buffer: pointers, occupancy level, transfer counter and handshake decode.
module leaf_stream_buffer
  import leaf_pkg::*;
#(
  parameter int unsigned DATA_W = LEAF_DATA_W,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  leaf_stream_buffer_if.slave bus
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LVL_W = LEAF_LVL_W(DEPTH);

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [CNT_W-1:0]  xfer_cnt_q, xfer_cnt_d;
  leaf_occ_e         occ_q, occ_d;
  logic              push, pop;
  logic              in_ready, out_valid;
  logic [DATA_W-1:0] rdata;

  // Handshake flags decode only the registered occupancy region.
  assign in_ready  = (occ_q != OCC_FULL);
  assign out_valid = (occ_q != OCC_EMPTY);
  assign push      = bus.in_valid && in_ready;
  assign pop       = out_valid && bus.out_ready;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    xfer_cnt_d = xfer_cnt_q;
    occ_d      = OCC_PARTIAL;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + AW'(1);
      xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
    end
    unique case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    if (level_d == '0)                  occ_d = OCC_EMPTY;
    else if (level_d == LVL_W'(DEPTH))  occ_d = OCC_FULL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      xfer_cnt_q <= '0;
      occ_q      <= OCC_EMPTY;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      xfer_cnt_q <= xfer_cnt_d;
      occ_q      <= occ_d;
    end
  end

  leaf_buf_mem #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr_q),
    .wdata(bus.in_data),
    .raddr(rd_ptr_q),
    .rdata(rdata)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_valid ? rdata : '0;
  assign bus.level     = level_q;
  assign bus.xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_leaf_stream_buffer.sv
// Directed, table-driven check of leaf_stream_buffer (DATA_W=8, DEPTH=4, CNT_W=16).
module tb_leaf_stream_buffer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  leaf_stream_buffer_if #(.DATA_W(8), .DEPTH(4), .CNT_W(16)) bus ();

  leaf_stream_buffer #(.DATA_W(8), .DEPTH(4), .CNT_W(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [7:0]  d;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [7:0]  e_d;
    logic [2:0]  e_lvl;
    logic [15:0] e_x;
  } vec_t;

  vec_t tbl[$];

  task automatic addv(input int iv, input int d, input int ordy, input int e_ir,
                      input int e_ov, input int e_d, input int e_lvl, input int e_x);
    vec_t v;
    v.iv    = 1'(iv);
    v.d     = 8'(d);
    v.ordy  = 1'(ordy);
    v.e_ir  = 1'(e_ir);
    v.e_ov  = 1'(e_ov);
    v.e_d   = 8'(e_d);
    v.e_lvl = 3'(e_lvl);
    v.e_x   = 16'(e_x);
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string nm, input int e_ir, input int e_ov, input int e_d,
                          input int e_lvl, input int e_x);
    chk({nm, ".in_ready"},  32'(bus.in_ready),  32'(e_ir));
    chk({nm, ".out_valid"}, 32'(bus.out_valid), 32'(e_ov));
    chk({nm, ".out_data"},  32'(bus.out_data),  32'(e_d));
    chk({nm, ".level"},     32'(bus.level),     32'(e_lvl));
    chk({nm, ".xfer_cnt"},  32'(bus.xfer_cnt),  32'(e_x));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_data   = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Reset held with random inputs.
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid  = 1'($urandom);
      bus.in_data   = 8'($urandom);
      bus.out_ready = 1'($urandom);
      step();
      chk_outs($sformatf("reset%0d", i), 1, 0, 0, 0, 0);
    end
    rst_n         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    step();
    chk_outs("post_reset", 1, 0, 0, 0, 0);

    // Fill, overflow drop, drain; then full push+pop and drain.
    addv(1, 'h11, 0, 1, 1, 'h11, 1, 0);
    addv(1, 'h22, 0, 1, 1, 'h11, 2, 0);
    addv(1, 'h33, 0, 1, 1, 'h11, 3, 0);
    addv(1, 'h44, 0, 0, 1, 'h11, 4, 0);
    addv(1, 'h55, 0, 0, 1, 'h11, 4, 0);
    addv(0, 'h00, 1, 1, 1, 'h22, 3, 1);
    addv(0, 'h00, 1, 1, 1, 'h33, 2, 2);
    addv(0, 'h00, 1, 1, 1, 'h44, 1, 3);
    addv(0, 'h00, 1, 1, 0, 'h00, 0, 4);
    addv(1, 'hA1, 0, 1, 1, 'hA1, 1, 4);
    addv(1, 'hA2, 0, 1, 1, 'hA1, 2, 4);
    addv(1, 'hA3, 0, 1, 1, 'hA1, 3, 4);
    addv(1, 'hA4, 0, 0, 1, 'hA1, 4, 4);
    addv(1, 'hB5, 1, 1, 1, 'hA2, 3, 5);
    addv(1, 'hB5, 0, 0, 1, 'hA2, 4, 5);
    addv(0, 'h00, 1, 1, 1, 'hA3, 3, 6);
    addv(0, 'h00, 1, 1, 1, 'hA4, 2, 7);
    addv(0, 'h00, 1, 1, 1, 'hB5, 1, 8);
    addv(0, 'h00, 1, 1, 0, 'h00, 0, 9);

    foreach (tbl[i]) begin
      bus.in_valid  = tbl[i].iv;
      bus.in_data   = tbl[i].d;
      bus.out_ready = tbl[i].ordy;
      step();
      chk_outs($sformatf("vec%0d", i), int'(tbl[i].e_ir), int'(tbl[i].e_ov),
               int'(tbl[i].e_d), int'(tbl[i].e_lvl), int'(tbl[i].e_x));
    end

    // Streaming across pointer wrap.
    do_reset();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(8'h60 + k);
      step();
      chk_outs($sformatf("wrap%0d", k), 1, 1, 8'h60 + k, 1, k);
    end
    bus.in_valid = 1'b0;
    step();
    chk_outs("wrap_end", 1, 0, 0, 0, 10);

    // Reset while two words are stored.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hD1;
    step();
    bus.in_data   = 8'hD2;
    step();
    chk_outs("pre_rst", 1, 1, 8'hD1, 2, 10);
    bus.in_valid  = 1'b0;
    rst_n         = 1'b0;
    #1;
    chk_outs("async_rst", 1, 0, 0, 0, 0);
    step();
    rst_n = 1'b1;
    step();
    chk_outs("after_rst", 1, 0, 0, 0, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hE1;
    step();
    chk_outs("fresh1", 1, 1, 8'hE1, 1, 0);
    bus.in_data  = 8'hE2;
    step();
    chk_outs("fresh2", 1, 1, 8'hE1, 2, 0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    chk_outs("fresh_pop1", 1, 1, 8'hE2, 1, 1);
    step();
    chk_outs("fresh_pop2", 1, 0, 0, 0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
